seq_circuit_scheduler: RTL and testbench

Round-robin scheduler that shares one `sequential_circuit` instance (inputs A, B, C; output O) among NREQ requesters. Each granted requester supplies a 3-bit {A,B,C} vector. The block drives that vector onto the shared circuit for HOLD cycles, samples O, and returns it with a one-cycle done pulse. It sits between the requesting logic and the `sequential_circuit` instance, and is the only driver of that instance's A/B/C.

---
 rtl/seq_circuit_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_seq_circuit_scheduler.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_circuit_scheduler.sv
// seq_circuit_scheduler
// Round-robin front end for one shared sequential_circuit. A granted
// requester's {A,B,C} vector is held on the circuit for HOLD cycles, then
// the circuit's O is sampled and returned with a one-cycle done pulse.
module seq_circuit_scheduler #(
   parameter int NREQ = 4,
   parameter int HOLD = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req,
   input  logic [3*NREQ-1:0] vec,
   input  logic              O_in,
   output logic              A,
   output logic              B,
   output logic              C,
   output logic [NREQ-1:0]   grant,
   output logic [NREQ-1:0]   done,
   output logic              result,
   output logic              busy
);

   localparam int unsigned NREQ_U = NREQ;
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
   localparam logic [PW-1:0] PTR_RESET = PW'(NREQ - 1);
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      APPLY = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      abc_q, abc_d;
   logic [NREQ-1:0] grant_q, grant_d;
   logic [NREQ-1:0] done_q, done_d;
   logic            result_q, result_d;
   logic            busy_q, busy_d;

   logic            found;
   logic [PW-1:0]   sel_idx;
   logic [2:0]      sel_vec;
   logic            hold_last;

   // Round-robin search: first requester above the pointer, wrapping around
   always_comb begin
      int unsigned cand;
      found   = 1'b0;
      sel_idx = '0;
      cand    = 0;
      for (int unsigned off = 1; off <= NREQ_U; off++) begin
         cand = (32'(ptr_q) + off) % NREQ_U;
         if (!found && req[cand]) begin
            found   = 1'b1;
            sel_idx = PW'(cand);
         end
      end
   end

   // Vector of the selected requester
   always_comb begin
      sel_vec = '0;
      for (int unsigned i = 0; i < NREQ_U; i++) begin
         if (32'(sel_idx) == i) begin
            sel_vec = vec[3*i +: 3];
         end
      end
   end

   assign hold_last = (cnt_q == HOLD_LAST);

   // State, pointer and hold-counter registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= PTR_RESET;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic; the pointer moves only when a grant is issued
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d = APPLY;
               ptr_d   = sel_idx;
               cnt_d   = '0;
            end
         end
         APPLY: begin
            // Counter reaches HOLD at most, which fits in CW bits
            cnt_d = cnt_q + CW'(1);
            if (hold_last) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Registered output values for the next cycle
   always_comb begin
      abc_d    = abc_q;
      grant_d  = grant_q;
      done_d   = '0;
      result_d = result_q;
      busy_d   = busy_q;
      case (state_q)
         IDLE: begin
            abc_d   = '0;
            grant_d = '0;
            busy_d  = 1'b0;
            if (found) begin
               abc_d   = sel_vec;
               grant_d = NREQ'(1) << sel_idx;
               busy_d  = 1'b1;
            end
         end
         APPLY: begin
            busy_d = 1'b1;
            if (hold_last) begin
               result_d = O_in;
               done_d   = grant_q;
            end
         end
         DONE: begin
            abc_d   = '0;
            grant_d = '0;
            busy_d  = 1'b0;
         end
         default: begin
            abc_d   = '0;
            grant_d = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // Output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         abc_q    <= '0;
         grant_q  <= '0;
         done_q   <= '0;
         result_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         abc_q    <= abc_d;
         grant_q  <= grant_d;
         done_q   <= done_d;
         result_q <= result_d;
         busy_q   <= busy_d;
      end
   end

   assign A      = abc_q[2];
   assign B      = abc_q[1];
   assign C      = abc_q[0];
   assign grant  = grant_q;
   assign done   = done_q;
   assign result = result_q;
   assign busy   = busy_q;

endmodule

// File: tb/tb_seq_circuit_scheduler.sv
// Directed bench for seq_circuit_scheduler: one instance with NREQ=4/HOLD=2
// and one with NREQ=2/HOLD=1, sharing a clock.
module tb_seq_circuit_scheduler;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   // Instance 0: NREQ=4, HOLD=2
   logic       reset0;
   logic [3:0] req0;
   logic [11:0] vec0;
   logic       o_in0;
   logic       a0, b0, c0;
   logic [3:0] grant0, done0;
   logic       result0, busy0;

   // Instance 1: NREQ=2, HOLD=1
   logic       reset1;
   logic [1:0] req1;
   logic [5:0] vec1;
   logic       o_in1;
   logic       a1, b1, c1;
   logic [1:0] grant1, done1;
   logic       result1, busy1;

   int n_checks = 0;
   int n_fail   = 0;

   seq_circuit_scheduler #(.NREQ(4), .HOLD(2)) dut0 (
      .clk(clk), .reset(reset0), .req(req0), .vec(vec0), .O_in(o_in0),
      .A(a0), .B(b0), .C(c0), .grant(grant0), .done(done0),
      .result(result0), .busy(busy0)
   );

   seq_circuit_scheduler #(.NREQ(2), .HOLD(1)) dut1 (
      .clk(clk), .reset(reset1), .req(req1), .vec(vec1), .O_in(o_in1),
      .A(a1), .B(b1), .C(c1), .grant(grant1), .done(done1),
      .result(result1), .busy(busy1)
   );

   // Advance one rising edge and settle 1 ns past it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Step until instance 0 leaves its transaction; ok=0 if the budget expires
   task automatic wait_idle0(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (busy0 === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      bit ok;
      reset0 = 1'b1;
      req0   = 4'b1111;
      vec0   = 12'h000;
      o_in0  = 1'b0;
      #10;
      step();
      n_checks++; if ({a0, b0, c0} !== 3'b000) begin n_fail++; $display("FAIL reset_abc got %b want 000", {a0, b0, c0}); end
      n_checks++; if (grant0 !== 4'b0000) begin n_fail++; $display("FAIL reset_grant got %b want 0000", grant0); end
      n_checks++; if (done0 !== 4'b0000) begin n_fail++; $display("FAIL reset_done got %b want 0000", done0); end
      n_checks++; if ({result0, busy0} !== 2'b00) begin n_fail++; $display("FAIL reset_result_busy got %b want 00", {result0, busy0}); end
      reset0 = 1'b0;
      step();
      n_checks++; if (grant0 !== 4'b0001) begin n_fail++; $display("FAIL reset_first_grant got %b want 0001", grant0); end
      n_checks++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL reset_first_busy got %b want 1", busy0); end
      req0 = 4'b0000;
      wait_idle0(ok);
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL reset_idle_timeout got %b want 1", ok); end
   endtask

   task automatic test_single();
      bit ok;
      req0  = 4'b0100;
      vec0  = 12'b000_011_000_000;
      o_in0 = 1'b1;
      step();
      n_checks++; if ({a0, b0, c0} !== 3'b011) begin n_fail++; $display("FAIL single_abc got %b want 011", {a0, b0, c0}); end
      n_checks++; if (grant0 !== 4'b0100) begin n_fail++; $display("FAIL single_grant got %b want 0100", grant0); end
      req0 = 4'b0000;
      step();
      n_checks++; if (done0 !== 4'b0000) begin n_fail++; $display("FAIL single_done_early got %b want 0000", done0); end
      n_checks++; if (grant0 !== 4'b0100) begin n_fail++; $display("FAIL single_grant_hold got %b want 0100", grant0); end
      step();
      n_checks++; if (done0 !== 4'b0100) begin n_fail++; $display("FAIL single_done got %b want 0100", done0); end
      n_checks++; if (result0 !== 1'b1) begin n_fail++; $display("FAIL single_result got %b want 1", result0); end
      step();
      n_checks++; if (grant0 !== 4'b0000) begin n_fail++; $display("FAIL single_grant_clear got %b want 0000", grant0); end
      n_checks++; if (done0 !== 4'b0000) begin n_fail++; $display("FAIL single_done_clear got %b want 0000", done0); end
      n_checks++; if ({a0, b0, c0, busy0} !== 4'b0000) begin n_fail++; $display("FAIL single_abc_busy_clear got %b want 0000", {a0, b0, c0, busy0}); end
      n_checks++; if (result0 !== 1'b1) begin n_fail++; $display("FAIL single_result_held got %b want 1", result0); end
      wait_idle0(ok);
   endtask

   task automatic test_round_robin();
      bit ok;
      logic [3:0] exp_g [6];
      exp_g = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
      // Pulse reset in IDLE so the pointer starts at NREQ-1
      reset0 = 1'b1;
      #2;
      reset0 = 1'b0;
      o_in0  = 1'b0;
      vec0   = 12'b001_010_011_100;
      req0   = 4'b1011;
      for (int k = 0; k < 6; k++) begin
         step();
         n_checks++; if (grant0 !== exp_g[k]) begin n_fail++; $display("FAIL rr_grant[%0d] got %b want %b", k, grant0, exp_g[k]); end
         for (int j = 0; j < 3; j++) begin
            step();
            n_checks++; if (grant0 !== ((j < 2) ? exp_g[k] : 4'b0000)) begin n_fail++; $display("FAIL rr_spacing[%0d.%0d] got %b want %b", k, j, grant0, (j < 2) ? exp_g[k] : 4'b0000); end
         end
      end
      req0 = 4'b0000;
      wait_idle0(ok);
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rr_idle_timeout got %b want 1", ok); end
   endtask

   task automatic test_drop_and_change();
      bit ok;
      int  pulses;
      req0  = 4'b0010;
      vec0  = 12'b000_000_101_000;
      o_in0 = 1'b0;
      step();
      n_checks++; if (grant0 !== 4'b0010) begin n_fail++; $display("FAIL drop_grant got %b want 0010", grant0); end
      n_checks++; if ({a0, b0, c0} !== 3'b101) begin n_fail++; $display("FAIL drop_abc got %b want 101", {a0, b0, c0}); end
      req0  = 4'b0000;
      vec0  = 12'b000_000_010_000;
      o_in0 = 1'b1;
      step();
      n_checks++; if ({a0, b0, c0} !== 3'b101) begin n_fail++; $display("FAIL drop_abc_held got %b want 101", {a0, b0, c0}); end
      pulses = 0;
      for (int j = 0; j < 4; j++) begin
         step();
         if (done0 === 4'b0010) pulses++;
         if (j == 0) begin
            n_checks++; if (result0 !== 1'b1) begin n_fail++; $display("FAIL drop_result got %b want 1", result0); end
         end
      end
      n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL drop_done_pulses got %0d want 1", pulses); end
      n_checks++; if (grant0 !== 4'b0000) begin n_fail++; $display("FAIL drop_no_regrant got %b want 0000", grant0); end
      wait_idle0(ok);
   endtask

   task automatic test_reset_mid();
      bit ok;
      req0  = 4'b0100;
      vec0  = 12'b000_111_000_000;
      o_in0 = 1'b1;
      step();
      n_checks++; if (grant0 !== 4'b0100) begin n_fail++; $display("FAIL rmid_grant got %b want 0100", grant0); end
      req0 = 4'b0000;
      step();
      reset0 = 1'b1;
      req0   = 4'b1010;
      vec0   = 12'b000_000_110_000;
      #1;
      n_checks++; if ({a0, b0, c0, busy0} !== 4'b0000) begin n_fail++; $display("FAIL rmid_abc_busy got %b want 0000", {a0, b0, c0, busy0}); end
      n_checks++; if (grant0 !== 4'b0000) begin n_fail++; $display("FAIL rmid_grant_clear got %b want 0000", grant0); end
      step();
      n_checks++; if (done0 !== 4'b0000) begin n_fail++; $display("FAIL rmid_no_done got %b want 0000", done0); end
      n_checks++; if (result0 !== 1'b0) begin n_fail++; $display("FAIL rmid_result got %b want 0", result0); end
      reset0 = 1'b0;
      step();
      n_checks++; if (grant0 !== 4'b0010) begin n_fail++; $display("FAIL rmid_first_grant got %b want 0010", grant0); end
      n_checks++; if ({a0, b0, c0} !== 3'b110) begin n_fail++; $display("FAIL rmid_abc got %b want 110", {a0, b0, c0}); end
      req0 = 4'b0000;
      wait_idle0(ok);
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rmid_idle_timeout got %b want 1", ok); end
   endtask

   task automatic test_hold1();
      logic [1:0] exp_g;
      logic [2:0] exp_abc;
      int          slot;
      vec1   = 6'b101_010;
      req1   = 2'b11;
      o_in1  = 1'b0;
      reset1 = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         o_in1 = c[0];
         step();
         slot  = (c - 1) / 3;
         exp_g = (slot % 2 == 0) ? 2'b01 : 2'b10;
         exp_abc = (slot % 2 == 0) ? 3'b010 : 3'b101;
         if (c % 3 == 1) begin
            n_checks++; if (grant1 !== exp_g) begin n_fail++; $display("FAIL h1_grant[%0d] got %b want %b", c, grant1, exp_g); end
            n_checks++; if ({a1, b1, c1} !== exp_abc) begin n_fail++; $display("FAIL h1_abc[%0d] got %b want %b", c, {a1, b1, c1}, exp_abc); end
            n_checks++; if (done1 !== 2'b00) begin n_fail++; $display("FAIL h1_done_early[%0d] got %b want 00", c, done1); end
         end else if (c % 3 == 2) begin
            n_checks++; if (done1 !== exp_g) begin n_fail++; $display("FAIL h1_done[%0d] got %b want %b", c, done1, exp_g); end
            n_checks++; if (result1 !== c[0]) begin n_fail++; $display("FAIL h1_result[%0d] got %b want %b", c, result1, c[0]); end
         end else begin
            n_checks++; if ({grant1, done1, busy1} !== 5'b00000) begin n_fail++; $display("FAIL h1_gap[%0d] got %b want 00000", c, {grant1, done1, busy1}); end
         end
      end
      req1 = 2'b00;
   endtask

   initial begin
      reset1 = 1'b1;
      req1   = 2'b00;
      vec1   = 6'b000000;
      o_in1  = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_drop_and_change();
      test_reset_mid();
      test_hold1();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
